// File: rtl/mult_div_unit.sv
// Sequential multiply/divide engine: radix-2 shift-add multiply and restoring divide,
// signed or unsigned, with a start/busy/done handshake and HI/LO results.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] CALC = 2'b01;
    localparam logic [1:0] FIX  = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [WIDTH-1:0] opd, opd_n;
    logic [WIDTH-1:0] a_raw, a_raw_n;
    logic             is_div, is_div_n;
    logic             neg_res, neg_res_n;
    logic             neg_rem, neg_rem_n;
    logic             dz, dz_n;
    logic             busy_n, done_n, div_zero_n;
    logic [WIDTH-1:0] hi_n, lo_n;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   sh_rem;
    logic [WIDTH:0]   diff;
    logic [ACC_W-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    // Operand magnitudes and the per-iteration datapath
    always_comb begin
        a_neg   = ~op[0] & a[WIDTH-1];
        b_neg   = ~op[0] & b[WIDTH-1];
        a_mag   = a_neg ? WIDTH'(0) - a : a;
        b_mag   = b_neg ? WIDTH'(0) - b : b;
        mul_sum = {1'b0, acc[ACC_W-1:WIDTH]} + {1'b0, opd};
        sh_rem  = acc[ACC_W-1:WIDTH-1];
        diff    = sh_rem - {1'b0, opd};
        prod    = neg_res ? ACC_W'(0) - acc : acc;
        quo     = neg_res ? WIDTH'(0) - acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = neg_rem ? WIDTH'(0) - acc[ACC_W-1:WIDTH] : acc[ACC_W-1:WIDTH];
    end

    // Next-state and next-register logic
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        acc_n      = acc;
        opd_n      = opd;
        a_raw_n    = a_raw;
        is_div_n   = is_div;
        neg_res_n  = neg_res;
        neg_rem_n  = neg_rem;
        dz_n       = dz;
        busy_n     = busy;
        done_n     = 1'b0;
        div_zero_n = div_zero;
        hi_n       = hi;
        lo_n       = lo;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = CALC;
                    busy_n     = 1'b1;
                    div_zero_n = 1'b0;
                    cnt_n      = CNT_W'(WIDTH);
                    is_div_n   = op[1];
                    a_raw_n    = a;
                    dz_n       = op[1] & (b == '0);
                    opd_n      = b_mag;
                    acc_n      = {WIDTH'(0), a_mag};
                    neg_res_n  = a_neg ^ b_neg;
                    neg_rem_n  = a_neg;
                end
            end
            CALC: begin
                if (abort) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = FIX;
                    end
                    // Divide: a set sign bit on the trial difference means restore
                    if (is_div) begin
                        acc_n = diff[WIDTH] ? {sh_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                            : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_n = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                                       : {1'b0, acc[ACC_W-1:1]};
                    end
                end
            end
            FIX: begin
                if (abort) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    state_n    = DONE;
                    done_n     = 1'b1;
                    div_zero_n = dz;
                    if (!is_div) begin
                        hi_n = prod[ACC_W-1:WIDTH];
                        lo_n = prod[WIDTH-1:0];
                    end else if (dz) begin
                        hi_n = a_raw;
                        lo_n = '1;
                    end else begin
                        hi_n = rem;
                        lo_n = quo;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opd      <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            opd      <= opd_n;
            a_raw    <= a_raw_n;
            is_div   <= is_div_n;
            neg_res  <= neg_res_n;
            neg_rem  <= neg_rem_n;
            dz       <= dz_n;
            busy     <= busy_n;
            done     <= done_n;
            div_zero <= div_zero_n;
            hi       <= hi_n;
            lo       <= lo_n;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: 32-bit and 8-bit instances, results, latency,
// divide-by-zero, overflow, ignored start, abort and asynchronous reset.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;

    logic        start32, abort32, busy32, done32, dz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;

    logic        start8, abort8, busy8, done8, dz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int checks;
    int failures;
    int edges;
    int done_seen;

    mult_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .abort(abort32), .busy(busy32), .done(done32), .div_zero(dz32),
        .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .abort(abort8), .busy(busy8), .done(done8), .div_zero(dz8),
        .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One 32-bit operation; optionally re-pulses start while busy at edge pulse_at
    task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int pulse_at,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int n;
        int bcnt;
        @(negedge clk);
        start32 = 1'b1; op32 = o; a32 = x; b32 = y;
        @(posedge clk); #1;
        start32 = 1'b0; op32 = ~o; a32 = ~x; b32 = y + 32'd1;
        n = 1;
        bcnt = int'(busy32);
        check({tag, "_dz_clear"}, 64'(dz32), 64'd0);
        while (!done32 && n < 100) begin
            start32 = (n == pulse_at - 1);
            @(posedge clk); #1;
            n++;
            bcnt += int'(busy32);
        end
        start32 = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd34);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd34);
        check({tag, "_hi"}, 64'(hi32), 64'(ehi));
        check({tag, "_lo"}, 64'(lo32), 64'(elo));
        check({tag, "_div_zero"}, 64'(dz32), 64'(edz));
        @(posedge clk); #1;
        check({tag, "_idle_after"}, 64'({busy32, done32}), 64'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0;
        start32 = 1'b0; abort32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        start8 = 1'b0; abort8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset32", 64'({busy32, done32, dz32, hi32, lo32} != '0), 64'd0);
        check("reset8", 64'({busy8, done8, dz8, hi8, lo8}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run32("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run32("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run32("mult_m1sq", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000, 32'h0000_0001, 1'b0);
        run32("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run32("divu", 2'b11, 32'h0000_0064, 32'h0000_0007, 0, 32'h0000_0002, 32'h0000_000E, 1'b0);
        run32("divu_zero", 2'b11, 32'h0000_0064, 32'h0000_0000, 0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        run32("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000, 32'h8000_0000, 1'b0);

        // Abort sampled at edge 10: no done, results untouched
        @(negedge clk);
        start32 = 1'b1; op32 = 2'b11; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk); #1;
        start32 = 1'b0;
        edges = 1;
        while (edges < 9) begin
            @(posedge clk); #1;
            edges++;
        end
        abort32 = 1'b1;
        @(posedge clk); #1;
        abort32 = 1'b0;
        check("abort_busy", 64'(busy32), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            done_seen += int'(done32);
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_hold", 64'({hi32, lo32}), 64'h0000_0000_8000_0000);

        // 8-bit signed multiply
        @(negedge clk);
        start8 = 1'b1; op8 = 2'b00; a8 = 8'h7F; b8 = 8'h80;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        edges = 1;
        while (!done8 && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        check("w8_latency", 64'(edges), 64'd10);
        check("w8_prod", 64'({hi8, lo8}), 64'h0000_0000_0000_C080);
        check("w8_busy_done", 64'({busy8, done8}), 64'd3);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        start32 = 1'b1; op32 = 2'b01; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", 64'({busy32, done32, dz32} != 3'b000 || hi32 != '0 || lo32 != '0), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("after_reset_idle", 64'({busy32, done32, hi32, lo32} != '0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
